pipe_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. Sits beside the IF/IF_ID/ID_EX/EX_MEM/MEM_WB chain and drives per-stage stall and flush controls. Arbitrates three hazard sources: taken branch/jump redirect from EX, multi-cycle EX operations, and load-use hazards from ID. Holds state across multi-cycle waits and post-redirect bubble windows.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_perf.sv | 26 ++
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_MCWAIT = 2'd1,
        CTRL_FLUSH  = 2'd2
    } ctrl_state_t;

    localparam int STALL_W = 5;

    // Hold bits: [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB
    localparam logic [STALL_W-1:0] STALL_NONE   = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_LD_USE = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_MC     = 5'b00111;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating event counters for stall cycles and redirect cycles.
// Latency: count visible one clock after the counted cycle.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module pipe_ctrl_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_evt,
    input  logic        redir_evt,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_redir_cnt_o
);

    // Count qualifying cycles, holding at the maximum value once reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= 32'd0;
            perf_redir_cnt_o <= 32'd0;
        end else begin
            if (stall_evt && (perf_stall_cnt_o != 32'hFFFF_FFFF))
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (redir_evt && (perf_redir_cnt_o != 32'hFFFF_FFFF))
                perf_redir_cnt_o <= perf_redir_cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard controller driving per-stage stall/flush for the 5-stage core; optional PIPE_CTRL_PERF_EN adds perf counters.
// Latency: zero-cycle from hazard inputs to controls; state changes at the next edge.
// Backpressure: multi-cycle EX ops stall PC/IF_ID/ID_EX until done or timeout.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC  = 0,
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ld_use_i,
    input  logic        ex_mc_req_i,
    input  logic        ex_mc_done_i,
    input  logic        ex_redirect_i,
    input  logic [63:0] ex_redirect_pc_i,
    output logic [4:0]  stall_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        flush_exmem_o,
    output logic        redirect_o,
    output logic [63:0] redirect_pc_o,
    output logic        busy_o,
    output logic        err_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_redir_cnt_o
`endif
);

    localparam logic [15:0] FLUSH_LEN = 16'(FLUSH_CYC);
    localparam logic [15:0] MC_LIMIT  = 16'(MC_TIMEOUT);

    ctrl_state_t  state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         err_q, err_d;

    logic [4:0]   stall_c;
    logic         flush_ifid_c, flush_idex_c, flush_exmem_c, redirect_c;

    // Next-state and Mealy control decode; redirect beats mc_req beats ld_use in RUN.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        stall_c       = STALL_NONE;
        flush_ifid_c  = 1'b0;
        flush_idex_c  = 1'b0;
        flush_exmem_c = 1'b0;
        redirect_c    = 1'b0;
        case (state_q)
            CTRL_RUN: begin
                if (ex_redirect_i) begin
                    redirect_c   = 1'b1;
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                    if (FLUSH_CYC > 0) begin
                        state_d = CTRL_FLUSH;
                        cnt_d   = FLUSH_LEN;
                    end
                end else if (ex_mc_req_i && !ex_mc_done_i) begin
                    stall_c       = STALL_MC;
                    flush_exmem_c = 1'b1;
                    state_d       = CTRL_MCWAIT;
                    cnt_d         = 16'd1;
                end else if (ex_mc_req_i && ex_mc_done_i) begin
                    // single-cycle completion: nothing to hold
                end else if (id_ld_use_i) begin
                    stall_c      = STALL_LD_USE;
                    flush_idex_c = 1'b1;
                end
            end
            CTRL_MCWAIT: begin
                if (ex_mc_done_i) begin
                    state_d = CTRL_RUN;
                    cnt_d   = 16'd0;
                end else if (cnt_q == MC_LIMIT) begin
                    // give up on the op: release exactly as a done would
                    err_d   = 1'b1;
                    state_d = CTRL_RUN;
                    cnt_d   = 16'd0;
                end else begin
                    stall_c       = STALL_MC;
                    flush_exmem_c = 1'b1;
                    cnt_d         = cnt_q + 16'd1;
                end
            end
            CTRL_FLUSH: begin
                if (ex_redirect_i) begin
                    redirect_c   = 1'b1;
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                    cnt_d        = FLUSH_LEN;
                end else begin
                    flush_ifid_c = 1'b1;
                    cnt_d        = cnt_q - 16'd1;
                    if (cnt_q == 16'd1)
                        state_d = CTRL_RUN;
                end
            end
            default: begin
                state_d = CTRL_RUN;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State, wait/bubble counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CTRL_RUN;
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // All outputs are forced low while reset is held.
    assign stall_o       = rst_n ? stall_c : STALL_NONE;
    assign flush_ifid_o  = rst_n & flush_ifid_c;
    assign flush_idex_o  = rst_n & flush_idex_c;
    assign flush_exmem_o = rst_n & flush_exmem_c;
    assign redirect_o    = rst_n & redirect_c;
    assign redirect_pc_o = redirect_o ? ex_redirect_pc_i : 64'd0;
    assign busy_o        = rst_n & (state_q != CTRL_RUN);
    assign err_o         = rst_n & err_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_evt        (|stall_o),
        .redir_evt        (redirect_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_redir_cnt_o (perf_redir_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two configurations driven in lockstep, checked every cycle against a reference model.
// Latency: outputs compared mid-cycle, model advanced at each rising edge.
// Backpressure: n/a.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ld_use, mc_req, mc_done, redir;
    logic [63:0] redir_pc;

    logic [4:0]  a_stall, b_stall;
    logic        a_fi, a_fd, a_fe, a_rd, a_busy, a_err;
    logic        b_fi, b_fd, b_fe, b_rd, b_busy, b_err;
    logic [63:0] a_pc, b_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] a_ps, a_pr, b_ps, b_pr;
`endif

    pipe_ctrl #(.FLUSH_CYC(2), .MC_TIMEOUT(8)) u_a (
        .clk(clk), .rst_n(rst_n), .id_ld_use_i(ld_use), .ex_mc_req_i(mc_req),
        .ex_mc_done_i(mc_done), .ex_redirect_i(redir), .ex_redirect_pc_i(redir_pc),
        .stall_o(a_stall), .flush_ifid_o(a_fi), .flush_idex_o(a_fd), .flush_exmem_o(a_fe),
        .redirect_o(a_rd), .redirect_pc_o(a_pc), .busy_o(a_busy), .err_o(a_err)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt_o(a_ps), .perf_redir_cnt_o(a_pr)
`endif
    );

    pipe_ctrl #(.FLUSH_CYC(0), .MC_TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .id_ld_use_i(ld_use), .ex_mc_req_i(mc_req),
        .ex_mc_done_i(mc_done), .ex_redirect_i(redir), .ex_redirect_pc_i(redir_pc),
        .stall_o(b_stall), .flush_ifid_o(b_fi), .flush_idex_o(b_fd), .flush_exmem_o(b_fe),
        .redirect_o(b_rd), .redirect_pc_o(b_pc), .busy_o(b_busy), .err_o(b_err)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt_o(b_ps), .perf_redir_cnt_o(b_pr)
`endif
    );

    wire [74:0] obs_a = {a_stall, a_fi, a_fd, a_fe, a_rd, a_pc, a_busy, a_err};
    wire [74:0] obs_b = {b_stall, b_fi, b_fd, b_fe, b_rd, b_pc, b_busy, b_err};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per configuration, whether a multi-cycle op is being waited on,
    // how many stall cycles it has received, how many bubble cycles remain, and the sticky error.
    int fc [2] = '{2, 0};
    int to [2] = '{8, 4};
    bit in_wait    [2];
    int waited     [2];
    int flush_left [2];
    bit err_m      [2];
    int stall_seen [2];
    int redir_seen [2];

    int a_stall_cyc, a_busy_cyc;

    task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model(input int i, input bit commit, output logic [74:0] e);
        logic [4:0]  st;
        logic        fi, fd, fe, rd, busy;
        logic [63:0] pc;
        bit nw, nerr;
        int nwait, nfl;
        st = 5'd0; fi = 0; fd = 0; fe = 0; rd = 0; pc = 64'd0;
        nw = in_wait[i]; nwait = waited[i]; nfl = flush_left[i]; nerr = err_m[i];
        busy = in_wait[i] || (flush_left[i] > 0);
        if (!rst_n) begin
            busy = 0; nw = 0; nwait = 0; nfl = 0; nerr = 0;
        end else if (in_wait[i]) begin
            if (mc_done) nw = 0;
            else if (waited[i] == to[i]) begin nw = 0; nerr = 1; end
            else begin st = 5'b00111; fe = 1; nwait = waited[i] + 1; end
        end else if (redir) begin
            rd = 1; pc = redir_pc; fi = 1; fd = 1; nfl = fc[i];
        end else if (flush_left[i] > 0) begin
            fi = 1; nfl = flush_left[i] - 1;
        end else if (mc_req && !mc_done) begin
            st = 5'b00111; fe = 1; nw = 1; nwait = 1;
        end else if (ld_use && !mc_req) begin
            st = 5'b00011; fd = 1;
        end
        e = {st, fi, fd, fe, rd, pc, busy, (rst_n ? err_m[i] : 1'b0)};
        if (commit) begin
            in_wait[i] = nw; waited[i] = nwait; flush_left[i] = nfl; err_m[i] = nerr;
            if (!rst_n) begin
                stall_seen[i] = 0; redir_seen[i] = 0;
            end else begin
                if (st != 5'd0) stall_seen[i]++;
                if (rd) redir_seen[i]++;
            end
        end
    endtask

    task automatic step(input string tag);
        logic [74:0] e;
        @(negedge clk);
        model(0, 1'b0, e);
        check({tag, "_a"}, obs_a, e);
        model(1, 1'b0, e);
        check({tag, "_b"}, obs_b, e);
        if (a_stall != 5'd0) a_stall_cyc++;
        if (a_busy) a_busy_cyc++;
        @(posedge clk);
        model(0, 1'b1, e);
        model(1, 1'b1, e);
        #1;
    endtask

    task automatic idle();
        ld_use = 0; mc_req = 0; mc_done = 0; redir = 0; redir_pc = 64'd0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        step("reset0");
        step("reset1");
        rst_n = 1;
        step("idle");

        // load-use for one cycle
        ld_use = 1; step("lduse");
        ld_use = 0; step("lduse_after");

        // multi-cycle op, done five cycles after the request
        rst_n = 0; step("rst_mc");
        rst_n = 1;
        a_stall_cyc = 0; a_busy_cyc = 0;
        mc_req = 1;
        for (int k = 0; k < 5; k++) step("mc_wait");
        mc_done = 1; step("mc_done");
        idle(); step("mc_after");
        check("mc_stall_cycles", 75'(a_stall_cyc), 75'd5);
        check("mc_busy_cycles", 75'(a_busy_cyc), 75'd5);

        // redirect with a two-cycle bubble window
        redir = 1; redir_pc = 64'h8000_0040; step("redir");
        idle();
        for (int k = 0; k < 3; k++) step("redir_flush");
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall", 75'(a_ps), 75'd5);
        check("perf_redir", 75'(a_pr), 75'd1);
`endif

        // all three hazards together: redirect wins
        redir = 1; mc_req = 1; ld_use = 1; redir_pc = 64'h1234_5678_9abc_def0;
        step("simul");
        idle();
        for (int k = 0; k < 3; k++) step("simul_after");

        // timeout: done never arrives
        rst_n = 0; step("rst_to");
        rst_n = 1;
        mc_req = 1;
        for (int k = 0; k < 10; k++) step("timeout");
        idle();
        for (int k = 0; k < 3; k++) step("timeout_after");
        check("err_sticky", 75'(b_err), 75'd1);

        // reset in the middle of a wait
        mc_req = 1; step("mc_again0"); step("mc_again1");
        rst_n = 0; step("rst_in_wait");
        rst_n = 1; idle(); step("after_rst");
        check("err_cleared", 75'(b_err), 75'd0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            redir    = ($urandom_range(0, 7) == 0);
            mc_req   = ($urandom_range(0, 3) == 0);
            mc_done  = ($urandom_range(0, 3) == 0);
            ld_use   = ($urandom_range(0, 3) == 0);
            redir_pc = {$urandom, $urandom};
            step("rand");
        end
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_rand_a", 75'(a_ps), 75'(stall_seen[0]));
        check("perf_redir_rand_a", 75'(a_pr), 75'(redir_seen[0]));
        check("perf_stall_rand_b", 75'(b_ps), 75'(stall_seen[1]));
        check("perf_redir_rand_b", 75'(b_pr), 75'(redir_seen[1]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
